// File: rtl/tone_decoder.sv
// Tone period decoder: measures the time between rising edges of a 1-bit square wave
// and locks onto one of eight notes after CONFIRM matching periods; flags silence on timeout.
module tone_decoder #(
   parameter int P0      = 45866,
   parameter int P1      = 40863,
   parameter int P2      = 36402,
   parameter int P3      = 34359,
   parameter int P4      = 30612,
   parameter int P5      = 27273,
   parameter int P6      = 24297,
   parameter int P7      = 22933,
   parameter int TOL     = 512,
   parameter int CONFIRM = 2,
   parameter int TIMEOUT = 100000
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       tone_in,
   output logic [2:0] note,
   output logic       note_valid,
   output logic       note_start,
   output logic       silence
);

   typedef enum logic [1:0] {IDLE, MEASURE, LOCKED} state_t;

   localparam logic [7:0][17:0] PT = {18'(P7), 18'(P6), 18'(P5), 18'(P4),
                                      18'(P3), 18'(P2), 18'(P1), 18'(P0)};
   localparam logic [17:0] TOLW  = 18'(TOL);
   localparam logic [2:0]  CONF3 = 3'(CONFIRM);
   localparam logic [16:0] TO17  = 17'(TIMEOUT);

   state_t      state, state_n;
   logic [2:0]  sync;
   logic        rise;
   logic [16:0] cnt, cnt_n;
   logic [2:0]  cand, cand_n, mcnt, mcnt_n, note_n;
   logic        valid_n, start_n, silence_n;
   logic        hit;
   logic [2:0]  hit_k;

   // sync[1:0] is the synchronizer, sync[2] the previous synchronized sample
   assign rise = sync[1] & ~sync[2];

   // cnt holds the elapsed period when an edge arrives; scan downward so the lowest index wins
   always_comb begin
      hit   = 1'b0;
      hit_k = '0;
      for (int k = 7; k >= 0; k--) begin
         if (({1'b0, cnt} + TOLW >= PT[k]) && ({1'b0, cnt} <= PT[k] + TOLW)) begin
            hit   = 1'b1;
            hit_k = k[2:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= IDLE;
         sync       <= '0;
         cnt        <= '0;
         cand       <= '0;
         mcnt       <= '0;
         note       <= '0;
         note_valid <= 1'b0;
         note_start <= 1'b0;
         silence    <= 1'b1;
      end else begin
         state      <= state_n;
         sync       <= {sync[1:0], tone_in};
         cnt        <= cnt_n;
         cand       <= cand_n;
         mcnt       <= mcnt_n;
         note       <= note_n;
         note_valid <= valid_n;
         note_start <= start_n;
         silence    <= silence_n;
      end
   end

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      cand_n    = cand;
      mcnt_n    = mcnt;
      note_n    = note;
      valid_n   = note_valid;
      start_n   = 1'b0;
      silence_n = silence;

      if (rise)
         cnt_n = 17'd1;
      else if (state != IDLE && cnt != '1)
         cnt_n = cnt + 17'd1;

      case (state)
         IDLE: begin
            silence_n = 1'b1;
            valid_n   = 1'b0;
            if (rise) begin
               state_n   = MEASURE;
               mcnt_n    = '0;
               silence_n = 1'b0;
            end
         end
         MEASURE: begin
            if (rise) begin
               if (!hit)
                  mcnt_n = '0;
               else if (hit_k == cand)
                  mcnt_n = mcnt + 3'd1;
               else begin
                  cand_n = hit_k;
                  mcnt_n = 3'd1;
               end
               if (hit && mcnt_n >= CONF3) begin
                  state_n = LOCKED;
                  note_n  = hit_k;
                  valid_n = 1'b1;
                  start_n = 1'b1;
               end
            end else if (cnt == TO17) begin
               state_n   = IDLE;
               cnt_n     = '0;
               silence_n = 1'b1;
               valid_n   = 1'b0;
            end
         end
         LOCKED: begin
            if (rise) begin
               if (!(hit && hit_k == note)) begin
                  state_n = MEASURE;
                  valid_n = 1'b0;
                  cand_n  = hit ? hit_k : cand;
                  mcnt_n  = hit ? 3'd1 : 3'd0;
               end
            end else if (cnt == TO17) begin
               state_n   = IDLE;
               cnt_n     = '0;
               silence_n = 1'b1;
               valid_n   = 1'b0;
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_tone_decoder.sv
// Randomized bench for tone_decoder: a note-level model predicts output events
// (lock, unlock, silence changes with their cycle), a monitor compares DUT changes.
module tb_tone_decoder;

   localparam int P0 = 717, P1 = 638, P2 = 569, P3 = 537;
   localparam int P4 = 478, P5 = 426, P6 = 380, P7 = 358;
   localparam int TOL = 8, CONFIRM = 2, TIMEOUT = 1600;
   localparam int LAG = 3;
   localparam int PER [8] = '{P0, P1, P2, P3, P4, P5, P6, P7};

   typedef struct {
      int         cyc;
      logic       st;
      logic       vl;
      logic       si;
      logic [2:0] nt;
   } ev_t;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       tone_in = 1'b0;
   logic [2:0] note;
   logic       note_valid, note_start, silence;

   int  cyc = 0;
   int  checks = 0;
   int  errors = 0;
   ev_t exp_q[$];

   // model state: note-level view of the decoder
   bit m_idle = 1'b1;
   int m_last = 0;
   int m_locked = -1;
   int m_run_note = -1;
   int m_run_len = 0;
   int m_held = 0;

   tone_decoder #(
      .P0(P0), .P1(P1), .P2(P2), .P3(P3), .P4(P4), .P5(P5), .P6(P6), .P7(P7),
      .TOL(TOL), .CONFIRM(CONFIRM), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rstn(rstn), .tone_in(tone_in),
      .note(note), .note_valid(note_valid), .note_start(note_start), .silence(silence)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int classify(int p);
      for (int k = 0; k < 8; k++) begin
         int d;
         d = p - PER[k];
         if (d < 0) d = -d;
         if (d <= TOL) return k;
      end
      return -1;
   endfunction

   task automatic push_ev(int t, logic st, logic vl, logic si, int nt);
      ev_t e;
      e.cyc = t; e.st = st; e.vl = vl; e.si = si; e.nt = 3'(nt);
      exp_q.push_back(e);
   endtask

   task automatic model_reset();
      m_idle = 1'b1; m_locked = -1; m_run_note = -1; m_run_len = 0; m_held = 0;
   endtask

   task automatic model_edge(int c);
      int k;
      if (m_idle) begin
         m_idle = 1'b0;
         m_run_len = 0;
         push_ev(c + LAG, 1'b0, 1'b0, 1'b0, m_held);
      end else begin
         k = classify(c - m_last);
         if (m_locked >= 0) begin
            if (k != m_locked) begin
               m_locked = -1;
               m_run_note = k;
               m_run_len = (k >= 0) ? 1 : 0;
               push_ev(c + LAG, 1'b0, 1'b0, 1'b0, m_held);
            end
         end else begin
            if (k < 0) m_run_len = 0;
            else if (k == m_run_note && m_run_len > 0) m_run_len++;
            else begin m_run_note = k; m_run_len = 1; end
            if (k >= 0 && m_run_len >= CONFIRM) begin
               m_locked = k;
               m_held = k;
               push_ev(c + LAG, 1'b1, 1'b1, 1'b0, k);
            end
         end
      end
      m_last = c;
   endtask

   // called at posedge+1; leaves the bench where the next rising edge would fall
   task automatic play(int per, int n);
      for (int i = 0; i < n; i++) begin
         tone_in = 1'b1;
         model_edge(cyc);
         repeat (per / 2) @(posedge clk);
         #1 tone_in = 1'b0;
         repeat (per - per / 2) @(posedge clk);
         #1;
      end
   endtask

   task automatic silence_wait();
      int tgt;
      tgt = cyc + 10;
      if (!m_idle) begin
         tgt = m_last + LAG + TIMEOUT;
         m_locked = -1;
         push_ev(tgt, 1'b0, 1'b0, 1'b1, m_held);
         m_idle = 1'b1;
      end
      while (cyc < tgt + 3) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain(string name);
      repeat (10) @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain_%s: %0d expected events never seen, first at cyc %0d", name,
                  exp_q.size(), exp_q[0].cyc);
         exp_q.delete();
      end
   endtask

   // monitor: reset values while rstn is low, otherwise every output change is an event
   logic       pv = 1'b0, ps = 1'b1;
   logic [2:0] pn = 3'd0;
   always @(negedge clk) begin
      if (!rstn) begin
         checks++;
         if (note !== 3'd0 || note_valid !== 1'b0 || note_start !== 1'b0 || silence !== 1'b1) begin
            errors++;
            $display("FAIL reset_vals cyc=%0d: got n=%0d v=%b st=%b s=%b, want n=0 v=0 st=0 s=1",
                     cyc, note, note_valid, note_start, silence);
         end
         pv = 1'b0; ps = 1'b1; pn = 3'd0;
      end else if (note_start || note_valid !== pv || silence !== ps || note !== pn) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event cyc=%0d: got n=%0d v=%b st=%b s=%b, none expected",
                     cyc, note, note_valid, note_start, silence);
         end else begin
            ev_t e;
            e = exp_q.pop_front();
            if (e.cyc != cyc || e.st !== note_start || e.vl !== note_valid ||
                e.si !== silence || e.nt !== note) begin
               errors++;
               $display("FAIL event: got cyc=%0d n=%0d v=%b st=%b s=%b, want cyc=%0d n=%0d v=%b st=%b s=%b",
                        cyc, note, note_valid, note_start, silence,
                        e.cyc, e.nt, e.vl, e.st, e.si);
            end
         end
         pv = note_valid; ps = silence; pn = note;
      end
   end

   initial begin
      // reset held with the input toggling
      for (int i = 0; i < 24; i++) begin
         @(posedge clk);
         #1 tone_in = (i % 6) < 3;
      end
      tone_in = 1'b0;
      repeat (3) @(posedge clk);
      #1 rstn = 1'b1;
      repeat (5) @(posedge clk);
      #1;

      // lock on note 2 and hold for 20 more periods
      play(P2, 23);
      // note change to 7
      play(P7, 3);
      drain("lock_change");
      silence_wait();

      // tolerance boundaries
      play(P4 + TOL, 4);
      play(P4 + TOL + 1, 4);
      play(600, 4);
      play(P4 - TOL, 3);
      play(P4 - TOL - 1, 3);
      drain("tolerance");
      silence_wait();

      // randomized periods around the note table
      for (int s = 0; s < 14; s++) begin
         int per;
         if ($urandom_range(0, 5) == 0) per = $urandom_range(300, 750);
         else per = PER[$urandom_range(0, 7)] + $urandom_range(0, 24) - 12;
         play(per, $urandom_range(1, 4));
         if ($urandom_range(0, 4) == 0) silence_wait();
      end
      drain("random");
      silence_wait();

      // timeout after a lock on note 5
      play(P5, 4);
      silence_wait();
      drain("timeout");

      // mid-lock reset, then relock from a fresh reference edge
      play(P0, 4);
      drain("pre_reset");
      rstn = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1 rstn = 1'b1;
      play(P0, 4);
      drain("relock");
      silence_wait();
      drain("final");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
